// File: rtl/seg7_scan_reader_if.sv
// Bus between a multiplexed 7-segment source and seg7_scan_reader.
// master = source side (drives segments/anodes), slave = reader side.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              i_Segmentos;
    logic [NUM_DIGITS-1:0]   i_Anodos;
    logic [4*NUM_DIGITS-1:0] o_Valor;
    logic                    o_Valido;
    logic [NUM_DIGITS-1:0]   o_Error;
    logic                    o_Timeout;

    modport master (
        output i_Segmentos, i_Anodos,
        input  o_Valor, o_Valido, o_Error, o_Timeout
    );

    modport slave (
        input  i_Segmentos, i_Anodos,
        output o_Valor, o_Valido, o_Error, o_Timeout
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and emits one word per frame.
// Optional frame timeout is enabled by defining SEG7_READER_TIMEOUT_EN.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int SAMPLE_DIV    = 16,
    parameter int STABLE_CNT    = 4,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    seg7_scan_reader_if.slave  bus
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    typedef enum logic [1:0] {SEARCH, SETTLE, HELD} state_t;

    // Returns {error, nibble}; unknown patterns decode to nibble 0 with error set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0001100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // Returns {valid, index}; valid only when exactly one anode is driven low.
    function automatic logic [IDX_W:0] anode_sel(input logic [NUM_DIGITS-1:0] an);
        int unsigned       zeros;
        logic [IDX_W-1:0]  idx;
        zeros = 0;
        idx   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!an[k]) begin
                zeros++;
                idx = IDX_W'(k);
            end
        end
        return {(zeros == 1), idx};
    endfunction

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [DIV_W-1:0]        div_q, div_d;
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              pat_q, pat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   captured_q, captured_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0] valor_q, valor_d;
    logic [NUM_DIGITS-1:0]   error_q, error_d;
    logic                    valido_q, valido_d;

    logic                    tick;
    logic                    an_valid;
    logic [IDX_W-1:0]        an_idx;
    logic [4:0]              dec;
    logic                    same;
    logic                    do_capture;

`ifdef SEG7_READER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_q, timeout_d;
`else
    logic                    unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_TICKS;
`endif

    always_comb begin
        div_d        = div_q + 1'b1;
        state_d      = state_q;
        idx_d        = idx_q;
        pat_d        = pat_q;
        cnt_d        = cnt_q;
        captured_d   = captured_q;
        shadow_val_d = shadow_val_q;
        shadow_err_d = shadow_err_q;
        valor_d      = valor_q;
        error_d      = error_q;
        valido_d     = 1'b0;
        do_capture   = 1'b0;

        tick               = (div_q == DIV_W'(SAMPLE_DIV - 1));
        {an_valid, an_idx} = anode_sel(an_q);
        dec                = decode(seg_q);
        same               = (an_idx == idx_q) && (seg_q == pat_q);

        if (tick) begin
            div_d = '0;
        end

        // Frame hand-off runs first so a capture landing on the same cycle survives the mask clear.
        if (&captured_q) begin
            valor_d    = shadow_val_q;
            error_d    = shadow_err_q;
            valido_d   = 1'b1;
            captured_d = '0;
        end

        if (tick) begin
            if (!an_valid) begin
                state_d = SEARCH;
            end else if (state_q == SETTLE && same) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
                    do_capture = 1'b1;
                    state_d    = HELD;
                end
            end else if (state_q == SEARCH || !same) begin
                idx_d = an_idx;
                pat_d = seg_q;
                cnt_d = CNT_W'(1);
                if (STABLE_CNT == 1) begin
                    do_capture = 1'b1;
                    state_d    = HELD;
                end else begin
                    state_d = SETTLE;
                end
            end
        end

        if (do_capture) begin
            shadow_val_d[int'(an_idx)*4 +: 4] = dec[3:0];
            shadow_err_d[an_idx]              = dec[4];
            captured_d[an_idx]                = 1'b1;
        end

`ifdef SEG7_READER_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        // Counter freezes once the flag is up so a recovering frame is not cut short again.
        if (&captured_q) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
        end else if (tick && !timeout_q) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
                tmo_cnt_d  = '0;
                timeout_d  = 1'b1;
                captured_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_Clk) begin
        seg_q        <= bus.i_Segmentos;
        an_q         <= bus.i_Anodos;
        idx_q        <= idx_d;
        pat_q        <= pat_d;
        shadow_val_q <= shadow_val_d;
        shadow_err_q <= shadow_err_d;
        if (i_Reset) begin
            div_q      <= '0;
            state_q    <= SEARCH;
            cnt_q      <= '0;
            captured_q <= '0;
            valor_q    <= '0;
            error_q    <= '0;
            valido_q   <= 1'b0;
        end else begin
            div_q      <= div_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            valor_q    <= valor_d;
            error_q    <= error_d;
            valido_q   <= valido_d;
        end
    end

`ifdef SEG7_READER_TIMEOUT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.o_Timeout = timeout_q;
`else
    assign bus.o_Timeout = 1'b0;
`endif

    assign bus.o_Valor  = valor_q;
    assign bus.o_Valido = valido_q;
    assign bus.o_Error  = error_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NUM_DIGITS=4, SAMPLE_DIV=4, STABLE_CNT=3).
// With SEG7_READER_TIMEOUT_EN defined only the timeout scenario runs, using TIMEOUT_TICKS=8.
module tb_seg7_scan_reader;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int SC = 3;
`ifdef SEG7_READER_TIMEOUT_EN
    localparam int TT = 8;
`else
    localparam int TT = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   vld_cnt = 0;
    int   v0;

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_reader #(
        .NUM_DIGITS(ND), .SAMPLE_DIV(SD), .STABLE_CNT(SC), .TIMEOUT_TICKS(TT)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_Valido === 1'b1) vld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each stimulus task starts and ends on a falling edge; n is a count of sample ticks.
    task automatic hold(input int d, input logic [6:0] pat, input int n);
        bus.i_Segmentos = pat;
        bus.i_Anodos    = ~(ND'(1) << d);
        repeat (SD * n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        bus.i_Segmentos = 7'h7F;
        bus.i_Anodos    = '1;
        repeat (SD * n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        hold(0, p0, 5);
        hold(1, p1, 5);
        hold(2, p2, 5);
        hold(3, p3, 5);
        blank(2);
    endtask

    initial begin
        bus.i_Segmentos = 7'h7F;
        bus.i_Anodos    = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_valor",   32'(bus.o_Valor),   32'h0);
        check("rst_valido",  32'(bus.o_Valido),  32'h0);
        check("rst_error",   32'(bus.o_Error),   32'h0);
        check("rst_timeout", 32'(bus.o_Timeout), 32'h0);

`ifdef SEG7_READER_TIMEOUT_EN
        v0 = vld_cnt;
        hold(0, 7'b1001111, 4);
        blank(2);
        check("tmo_before", 32'(bus.o_Timeout), 32'h0);
        blank(4);
        check("tmo_set", 32'(bus.o_Timeout), 32'h1);
        check("tmo_no_vld", 32'(vld_cnt - v0), 32'h0);
        blank(4);
        check("tmo_sticky", 32'(bus.o_Timeout), 32'h1);
        v0 = vld_cnt;
        frame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
        check("tmo_frame_vld", 32'(vld_cnt - v0), 32'h1);
        check("tmo_frame_valor", 32'(bus.o_Valor), 32'h4321);
        check("tmo_cleared", 32'(bus.o_Timeout), 32'h0);
`else
        v0 = vld_cnt;
        frame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
        check("full_vld",     32'(vld_cnt - v0),   32'h1);
        check("full_valor",   32'(bus.o_Valor),    32'h4321);
        check("full_error",   32'(bus.o_Error),    32'h0);
        check("full_timeout", 32'(bus.o_Timeout),  32'h0);

        v0 = vld_cnt;
        frame(7'b0000001, 7'b0000001, 7'b1111110, 7'b0000001);
        check("illegal_vld",   32'(vld_cnt - v0), 32'h1);
        check("illegal_valor", 32'(bus.o_Valor),  32'h0000);
        check("illegal_error", 32'(bus.o_Error),  32'b0100);

        v0 = vld_cnt;
        hold(0, 7'b0001000, 2);
        hold(0, 7'b0110001, 3);
        hold(1, 7'b0000001, 5);
        hold(2, 7'b0000001, 5);
        hold(3, 7'b0000001, 5);
        blank(2);
        check("glitch_vld",   32'(vld_cnt - v0), 32'h1);
        check("glitch_valor", 32'(bus.o_Valor),  32'h000C);
        check("glitch_error", 32'(bus.o_Error),  32'h0);

        v0 = vld_cnt;
        bus.i_Segmentos = 7'b0000001;
        bus.i_Anodos    = 4'b0011;
        repeat (SD * 10) @(negedge clk);
        blank(2);
        check("multi_vld",   32'(vld_cnt - v0), 32'h0);
        check("multi_valor", 32'(bus.o_Valor),  32'h000C);

        hold(0, 7'b0000001, 5);
        hold(1, 7'b1001111, 5);
        hold(2, 7'b0010010, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_valor", 32'(bus.o_Valor), 32'h0);
        v0 = vld_cnt;
        hold(3, 7'b0000110, 5);
        blank(2);
        check("midrst_no_vld", 32'(vld_cnt - v0), 32'h0);
        hold(0, 7'b0001111, 5);
        hold(1, 7'b0000000, 5);
        hold(2, 7'b0001100, 5);
        blank(2);
        check("midrst_vld",   32'(vld_cnt - v0), 32'h1);
        check("midrst_valor", 32'(bus.o_Valor),  32'h3987);
        check("midrst_tmo",   32'(bus.o_Timeout), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
